// File: rtl/cpu_pkg.sv
// Shared CPU-slice definitions: register-file geometry and the state encoding
// used by the register dump reader.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Register dump reader: on a start pulse, walks register indices lo..hi,
// reads each through a dedicated register-file read port and streams the
// values out over a valid/ready interface.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start              one-cycle request, sampled only while idle
//   lo_idx, hi_idx     index range, latched on an accepted start
//   abort              cancel an in-progress dump (FETCH/SEND only)
//   rd_addr, rd_data   register-file read port (rd_data is combinational)
//   out_valid/ready    beat handshake
//   out_data, out_idx  register value and its index
//   out_last           beat carries hi_idx
//   busy               dump in progress; selects this block onto the read port
//   done               one-cycle pulse on completion or abort
module reg_dump_reader
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = cpu_pkg::REG_ADDR_W,
  parameter int unsigned DATA_W   = cpu_pkg::REG_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] lo_idx,
  input  logic [ADDR_W-1:0] hi_idx,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  // Highest legal index; an out-of-range hi is clamped so the walk can never
  // run past the register file.
  localparam logic [ADDR_W-1:0] MaxIdx = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] hi_q, hi_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hi_d        = hi_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (lo_idx <= hi_idx) begin
            ptr_d   = lo_idx;
            hi_d    = (hi_idx > MaxIdx) ? MaxIdx : hi_idx;
            state_d = FETCH;
          end else begin
            // Empty range: report completion without emitting any beat.
            state_d = DONE;
          end
        end
      end

      FETCH: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
        end else begin
          // Register 0 is hard-wired zero regardless of what the port returns.
          out_data_d  = (ptr_q == '0) ? '0 : rd_data;
          out_idx_d   = ptr_q;
          out_last_d  = (ptr_q == hi_q);
          out_valid_d = 1'b1;
          state_d     = SEND;
        end
      end

      SEND: begin
        // Abort wins over a simultaneous handshake: the beat is dropped.
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          // Terminate on the compare so hi == MaxIdx never relies on wrap.
          if (ptr_q == hi_q) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hi_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hi_q        <= hi_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  // The read port always presents ptr; the external mux decides via busy.
  assign rd_addr   = ptr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == FETCH) || (state_q == SEND);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed self-checking bench for reg_dump_reader with a behavioural
// register file (reg[i] = 0x1000 + i; reg0 deliberately nonzero so the
// DUT's zero-forcing of index 0 is visible).
module tb_reg_dump_reader;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [4:0]  lo_idx;
  logic [4:0]  hi_idx;
  logic        abort;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_cmp;
  int n_fail;

  logic [31:0] b_data [64];
  logic [4:0]  b_idx  [64];
  logic        b_last [64];

  reg_dump_reader dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .lo_idx    (lo_idx),
    .hi_idx    (hi_idx),
    .abort     (abort),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  always @(posedge clk) begin
    if (wr_en) regs[wr_addr] <= wr_data;
  end

  // Start a dump with out_ready tied high and collect every handshaken beat.
  // Optionally write 0xDEAD to reg 6 on the FETCH edge of index 6.
  task automatic run_dump(input logic [4:0] lo, input logic [4:0] hi, input bit arm_wr,
                          output int nbeats, output int done_cyc, output logic busy_at_done);
    int cyc;
    @(negedge clk);
    lo_idx    = lo;
    hi_idx    = hi;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    cyc          = 1;
    nbeats       = 0;
    done_cyc     = -1;
    busy_at_done = 1'bx;
    while (cyc < 200) begin
      if (wr_en) wr_en = 1'b0;
      if (out_valid && out_ready && nbeats < 64) begin
        b_data[nbeats] = out_data;
        b_idx[nbeats]  = out_idx;
        b_last[nbeats] = out_last;
        nbeats++;
      end
      if (arm_wr && busy && !out_valid && rd_addr == 5'd6) begin
        wr_en   = 1'b1;
        wr_addr = 5'd6;
        wr_data = 32'h0000_DEAD;
      end
      if (done) begin
        done_cyc     = cyc;
        busy_at_done = busy;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({out_valid, out_data, out_idx, out_last, busy, done, rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b data=%h idx=%0d last=%b busy=%b done=%b addr=%0d, want all 0",
               out_valid, out_data, out_idx, out_last, busy, done, rd_addr);
    end
  endtask

  task automatic test_full_dump();
    int   nb, dc;
    logic bd;
    logic [31:0] exp_d;
    run_dump(5'd0, 5'd31, 1'b0, nb, dc, bd);
    n_cmp++;
    if (nb !== 32) begin
      n_fail++;
      $display("FAIL full_count: got %0d beats, want 32", nb);
    end
    n_cmp++;
    if (dc !== 65) begin
      n_fail++;
      $display("FAIL full_done_cycle: got %0d, want 65", dc);
    end
    n_cmp++;
    if (bd !== 1'b0) begin
      n_fail++;
      $display("FAIL full_busy_at_done: got %b, want 0", bd);
    end
    for (int i = 0; i < 32 && i < nb; i++) begin
      exp_d = (i == 0) ? 32'h0 : 32'h1000 + 32'(i);
      n_cmp++;
      if (b_idx[i] !== 5'(i) || b_data[i] !== exp_d || b_last[i] !== (i == 31)) begin
        n_fail++;
        $display("FAIL full_beat%0d: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                 i, b_idx[i], b_data[i], b_last[i], i, exp_d, (i == 31));
      end
    end
  endtask

  // Three stalled edges per beat; a start pulse mid-dump must be ignored.
  task automatic test_stall();
    int cyc, wcnt, nb, dc;
    logic [31:0] h_data;
    logic [4:0]  h_idx;
    logic        h_last;
    @(negedge clk);
    lo_idx    = 5'd5;
    hi_idx    = 5'd7;
    start     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    wcnt  = 0;
    nb    = 0;
    dc    = -1;
    h_data = '0;
    h_idx  = '0;
    h_last = 1'b0;
    while (cyc < 200) begin
      if (cyc == 3) begin
        start  = 1'b1;
        lo_idx = 5'd0;
        hi_idx = 5'd0;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dc = cyc;
        break;
      end else if (out_valid) begin
        if (wcnt == 0) begin
          h_data    = out_data;
          h_idx     = out_idx;
          h_last    = out_last;
          out_ready = 1'b0;
          wcnt      = 1;
        end else begin
          n_cmp++;
          if (out_data !== h_data || out_idx !== h_idx || out_last !== h_last) begin
            n_fail++;
            $display("FAIL stall_hold: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                     out_idx, out_data, out_last, h_idx, h_data, h_last);
          end
          if (wcnt == 3) begin
            if (nb < 64) begin
              b_data[nb] = out_data;
              b_idx[nb]  = out_idx;
              b_last[nb] = out_last;
            end
            nb++;
            out_ready = 1'b1;
            wcnt      = 0;
          end else begin
            wcnt++;
          end
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (nb !== 3) begin
      n_fail++;
      $display("FAIL stall_count: got %0d beats, want 3", nb);
    end
    n_cmp++;
    if (dc !== 16) begin
      n_fail++;
      $display("FAIL stall_done_cycle: got %0d, want 16", dc);
    end
    for (int i = 0; i < 3 && i < nb; i++) begin
      n_cmp++;
      if (b_idx[i] !== 5'(5 + i) || b_data[i] !== 32'h1005 + 32'(i) || b_last[i] !== (i == 2)) begin
        n_fail++;
        $display("FAIL stall_beat%0d: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                 i, b_idx[i], b_data[i], b_last[i], 5 + i, 32'h1005 + 32'(i), (i == 2));
      end
    end
  endtask

  task automatic test_empty_range();
    int cyc;
    int seen_busy, seen_valid, done_cnt, done_cyc;
    @(negedge clk);
    lo_idx    = 5'd9;
    hi_idx    = 5'd3;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    seen_busy  = 0;
    seen_valid = 0;
    done_cnt   = 0;
    done_cyc   = -1;
    for (cyc = 1; cyc <= 5; cyc++) begin
      if (busy) seen_busy++;
      if (out_valid) seen_valid++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc < 5) @(negedge clk);
    end
    n_cmp++;
    if (done_cyc !== 1 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL empty_done: got cycle=%0d pulses=%0d, want cycle=1 pulses=1", done_cyc, done_cnt);
    end
    n_cmp++;
    if (seen_busy !== 0 || seen_valid !== 0) begin
      n_fail++;
      $display("FAIL empty_quiet: got busy_cycles=%0d valid_cycles=%0d, want 0 and 0",
               seen_busy, seen_valid);
    end
  endtask

  task automatic test_abort();
    int cyc, nb, abort_cyc;
    @(negedge clk);
    lo_idx    = 5'd2;
    hi_idx    = 5'd10;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cyc       = 1;
    nb        = 0;
    abort_cyc = -1;
    while (cyc < 200) begin
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        abort = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || done !== 1'b1) begin
          n_fail++;
          $display("FAIL abort_next: got valid=%b done=%b, want valid=0 done=1", out_valid, done);
        end
        break;
      end
      if (out_valid && out_idx == 5'd4 && abort_cyc < 0) begin
        abort     = 1'b1;
        abort_cyc = cyc;
      end else if (out_valid && out_ready) begin
        if (nb < 64) b_idx[nb] = out_idx;
        nb++;
      end
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0;
    n_cmp++;
    if (abort_cyc !== 6) begin
      n_fail++;
      $display("FAIL abort_reach: idx 4 seen at cycle %0d, want 6", abort_cyc);
    end
    n_cmp++;
    if (nb !== 2 || b_idx[0] !== 5'd2 || b_idx[1] !== 5'd3) begin
      n_fail++;
      $display("FAIL abort_beats: got %0d beats (idx %0d,%0d), want 2 beats (idx 2,3)",
               nb, b_idx[0], b_idx[1]);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_async_reset();
    int   cyc, done_seen, nb, dc;
    logic bd;
    @(negedge clk);
    lo_idx    = 5'd0;
    hi_idx    = 5'd31;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 1; cyc < 25; cyc++) @(negedge clk);
    n_cmp++;
    if (rd_addr !== 5'd12 || busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pre: got addr=%0d busy=%b valid=%b, want addr=12 busy=1 valid=0",
               rd_addr, busy, out_valid);
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_idx, out_last, busy, done, rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got valid=%b data=%h idx=%0d last=%b busy=%b done=%b addr=%0d, want all 0",
               out_valid, out_data, out_idx, out_last, busy, done, rd_addr);
    end
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0) begin
      n_fail++;
      $display("FAIL rst_no_done: got %0d done cycles, want 0", done_seen);
    end
    run_dump(5'd0, 5'd0, 1'b0, nb, dc, bd);
    n_cmp++;
    if (nb !== 1 || b_idx[0] !== 5'd0 || b_data[0] !== 32'h0 || b_last[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_single: got %0d beats idx=%0d data=%h last=%b, want 1 beat idx=0 data=0 last=1",
               nb, b_idx[0], b_data[0], b_last[0]);
    end
    n_cmp++;
    if (dc !== 3) begin
      n_fail++;
      $display("FAIL rst_single_done: got cycle %0d, want 3", dc);
    end
  endtask

  task automatic test_coherence();
    int   nb, dc;
    logic bd;
    run_dump(5'd5, 5'd7, 1'b1, nb, dc, bd);
    n_cmp++;
    if (nb !== 3 || b_idx[1] !== 5'd6 || b_data[1] !== 32'h0000_1006) begin
      n_fail++;
      $display("FAIL coh_old: got %0d beats idx=%0d data=%h, want 3 beats idx=6 data=00001006",
               nb, b_idx[1], b_data[1]);
    end
    run_dump(5'd5, 5'd7, 1'b0, nb, dc, bd);
    n_cmp++;
    if (nb !== 3 || b_idx[1] !== 5'd6 || b_data[1] !== 32'h0000_DEAD) begin
      n_fail++;
      $display("FAIL coh_new: got %0d beats idx=%0d data=%h, want 3 beats idx=6 data=0000dead",
               nb, b_idx[1], b_data[1]);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rstn      = 1'b0;
    start     = 1'b0;
    lo_idx    = '0;
    hi_idx    = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
    repeat (2) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    test_full_dump();
    test_stall();
    test_empty_range();
    test_abort();
    test_async_reset();
    test_coherence();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug/readback initiator on the register-file read side. On a start pulse it walks a register index range (lo..hi), issues one read per index through a dedicated register-file read port, and streams each value out over a valid/ready interface. It sits between the single-cycle datapath's register file (second read port, muxed in while `busy`) and the lab testbench or UART dump logic.

## Interface
- `NUM_REGS`, 32: register count; indices 0..NUM_REGS-1.
- `ADDR_W`, 5: register index width.
- `DATA_W`, 32: register width.

- `clk`  in  1  clock; all state updates on posedge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `lo_idx`  in  ADDR_W  first index, latched on accepted start.
- `hi_idx`  in  ADDR_W  last index, latched on accepted start.
- `abort`  in  1  cancel the dump in progress.
- `rd_addr`  out  ADDR_W  read address to the register-file read port.
- `rd_data`  in  DATA_W  combinational read data for `rd_addr`.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  DATA_W  register value.
- `out_idx`  out  ADDR_W  index of `out_data`.
- `out_last`  out  1  beat is the final index (`hi_idx`).
- `busy`  out  1  high in FETCH/SEND.
- `done`  out  1  one-cycle pulse at completion or abort.

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - `start`=1 with lo≤hi: latch lo/hi, set ptr=lo, go to FETCH.
  - `start`=1 with lo>hi: go to DONE; no beats are emitted.
- FETCH:
  - Drive `rd_addr`=ptr.
  - On the edge, capture `rd_data` into `out_data` and ptr into `out_idx`; set `out_last` = (ptr==hi), `out_valid`=1; go to SEND.
  - Index 0 is captured as 0 regardless of `rd_data`.
- SEND:
  - Hold `out_data`/`out_idx`/`out_last` stable while `out_valid` && !`out_ready`.
  - On handshake: if ptr==hi go to DONE, else ptr+1 and go to FETCH.
- DONE: `done`=1 for exactly one cycle; go to IDLE.
- `abort`:
  - In FETCH/SEND, `abort` takes priority over the handshake: go to DONE and clear `out_valid` on the same edge. A beat presented in that cycle counts as not transferred.
  - In IDLE/DONE, `abort` is ignored.
- `start` while busy is ignored; lo/hi are not re-latched.
- ptr arithmetic is ADDR_W bits. hi ≤ NUM_REGS-1 guarantees no wrap. hi=31 terminates on the compare, not on overflow.
- Coherence: each value is sampled at its FETCH edge. A register-file write on that same edge is not visible, because the read sees the old value. Writes landing after the FETCH edge are not reflected.
- `rd_addr` outside FETCH is held at ptr; the port mux uses `busy`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `busy`=0, `done`=0, `rd_addr`=0; state IDLE.
- Reset asserted mid-dump returns to IDLE immediately, with no `done` pulse.
- Start accepted at edge N: FETCH during N→N+1; `out_valid` high from N+1.
- Minimum beat period is 2 cycles (FETCH + SEND) with `out_ready` tied high.
- Full 0..31 dump with `out_ready`=1: last handshake at start+64 cycles; `done` the cycle after.
- A new `start` is accepted the cycle after `done`.
- `out_*` are registered outputs. `rd_addr` is registered from ptr.

## Structure
- Shared package `cpu_pkg`: `REG_ADDR_W`, `REG_DATA_W`, `NUM_REGS`, and the state enum `dump_state_t` {IDLE, FETCH, SEND, DONE}.
- Single module, no sub-module; the output holding register is inline.
- The top-level port mux into the register file lives outside this block.

## Test plan
- Preload reg[i]=0x1000+i, with reg0 reading as 0. Start lo=0, hi=31, `out_ready`=1: expect 32 beats with idx 0..31, data 0, 0x1001..0x101F, `out_last` only on idx 31, and `done` at cycle 65.
- Start lo=5, hi=7, `out_ready` low 3 cycles on each beat: expect data held stable while stalled, exactly 3 beats, idx 5, 6, 7.
- Start lo=9, hi=3: expect no `out_valid`, `done` pulse 1 cycle after start, `busy` never high.
- Abort during SEND of idx 4 (lo=2, hi=10) with `out_ready`=1 in the same cycle: expect `out_valid` low next cycle, beats 2 and 3 only, `done`=1.
- Reset asserted asynchronously mid-dump (idx 12 in FETCH): expect all outputs 0 immediately and no `done`. A later start lo=0, hi=0 yields a single beat with data 0 and `out_last`=1.
- Register-file write to reg 6 (0xDEAD) on the FETCH edge of idx 6: expect the old value streamed. Rerun the dump: expect 0xDEAD.
